// File: rtl/level_classifier_pkg.sv
// Shared constants and helpers for the level classifier.
package level_classifier_pkg;

   localparam int MAX_CLASS  = 8;
   localparam int DEF_THR_LO = 32;
   localparam int DEF_THR_HI = 96;

   // Class-index width for n bands; a single band still needs one bit.
   function automatic int class_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/level_classifier_cand.sv
// Combinational band candidate: threshold count with downward hysteresis.
module level_classifier_cand
   import level_classifier_pkg::*;
#(
   parameter int WIDTH   = 7,
   parameter int N_CLASS = 3,
   parameter int CLASS_W = class_w(N_CLASS),
   parameter int HYST    = 2
) (
   input  logic [WIDTH-1:0]                sample,
   input  logic [N_CLASS-2:0][WIDTH-1:0]   thr,
   input  logic [CLASS_W-1:0]              cur,
   output logic [CLASS_W-1:0]              cand
);

   always_comb begin
      int raw_n;
      int low_n;
      int lo_thr;
      // NOTE: every variable gets a default first so no path can infer a latch.
      raw_n  = 0;
      low_n  = 0;
      lo_thr = 0;
      cand   = cur;
      for (int i = 0; i < N_CLASS - 1; i++) begin
         if (sample >= thr[i]) raw_n++;
         lo_thr = int'(thr[i]) - HYST;
         if (lo_thr < 0) lo_thr = 0;
         if (int'(sample) >= lo_thr) low_n++;
      end
      // Moving up uses the plain thresholds; moving down must clear T-HYST.
      if (raw_n >= int'(cur)) begin
         cand = CLASS_W'(raw_n);
      end else if (low_n < int'(cur)) begin
         cand = CLASS_W'(low_n);
      end
   end

endmodule

// File: rtl/level_classifier.sv
// Programmable N-band level classifier with hysteresis and dwell filter.
// Build option: LEVEL_CLASSIFIER_DWELL_EN enables the dwell (debounce) filter.
module level_classifier
   import level_classifier_pkg::*;
#(
   parameter int WIDTH   = 7,
   parameter int N_CLASS = 3,
   parameter int CLASS_W = class_w(N_CLASS),
   parameter int HYST    = 2,
   parameter int DWELL   = 4,
   parameter logic [(N_CLASS-1)*WIDTH-1:0] THR_INIT = {WIDTH'(DEF_THR_HI), WIDTH'(DEF_THR_LO)},
   parameter int RESET_CLASS = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   sample,
   input  logic               sample_valid,
   input  logic               thr_we,
   input  logic [2:0]         thr_idx,
   input  logic [WIDTH-1:0]   thr_data,
   output logic [CLASS_W-1:0] class_out,
   output logic               class_valid,
   output logic               changed,
   output logic               dir_up
);

   typedef logic [N_CLASS-2:0][WIDTH-1:0] thr_t;

   if (N_CLASS < 2 || N_CLASS > MAX_CLASS || DWELL < 1 || CLASS_W != class_w(N_CLASS)) begin : g_param_err
      $error("level_classifier: illegal parameter set");
   end

   thr_t               thr_q, thr_d;
   logic [CLASS_W-1:0] class_q, class_d;
   logic               class_valid_q, class_valid_d;
   logic               changed_q, changed_d;
   logic               dir_up_q, dir_up_d;
   logic [CLASS_W-1:0] cand;
   logic               wr_ok;

`ifdef LEVEL_CLASSIFIER_DWELL_EN
   localparam int CNT_W = $clog2(DWELL + 1);
   logic [CLASS_W-1:0] pend_q, pend_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   level_classifier_cand #(
      .WIDTH   (WIDTH),
      .N_CLASS (N_CLASS),
      .CLASS_W (CLASS_W),
      .HYST    (HYST)
   ) u_cand (
      .sample (sample),
      .thr    (thr_q),
      .cur    (class_q),
      .cand   (cand)
   );

   always_comb begin
      thr_d         = thr_q;
      class_d       = class_q;
      class_valid_d = sample_valid;
      changed_d     = 1'b0;
      dir_up_d      = dir_up_q;
      wr_ok         = 1'b0;
`ifdef LEVEL_CLASSIFIER_DWELL_EN
      pend_d        = pend_q;
      cnt_d         = cnt_q;
`endif
      // Out-of-range indices match nothing, so those writes are fully ignored.
      for (int i = 0; i < N_CLASS - 1; i++) begin
         if (thr_we && thr_idx == 3'(i)) begin
            thr_d[i] = thr_data;
            wr_ok    = 1'b1;
         end
      end

      if (wr_ok) begin
`ifdef LEVEL_CLASSIFIER_DWELL_EN
         cnt_d = '0;
`endif
      end else if (sample_valid) begin
`ifdef LEVEL_CLASSIFIER_DWELL_EN
         if (cand == class_q) begin
            cnt_d = '0;
         end else begin
            logic [CNT_W-1:0] cnt_nxt;
            if (cand == pend_q) begin
               cnt_nxt = cnt_q + 1'b1;
            end else begin
               cnt_nxt = CNT_W'(1);
            end
            pend_d = cand;
            if (cnt_nxt == CNT_W'(DWELL)) begin
               class_d   = cand;
               cnt_d     = '0;
               changed_d = 1'b1;
               dir_up_d  = (cand > class_q);
            end else begin
               cnt_d = cnt_nxt;
            end
         end
`else
         if (cand != class_q) begin
            class_d   = cand;
            changed_d = 1'b1;
            dir_up_d  = (cand > class_q);
         end
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         thr_q         <= thr_t'(THR_INIT);
         class_q       <= CLASS_W'(RESET_CLASS);
         class_valid_q <= 1'b0;
         changed_q     <= 1'b0;
         dir_up_q      <= 1'b0;
`ifdef LEVEL_CLASSIFIER_DWELL_EN
         pend_q        <= '0;
         cnt_q         <= '0;
`endif
      end else begin
         thr_q         <= thr_d;
         class_q       <= class_d;
         class_valid_q <= class_valid_d;
         changed_q     <= changed_d;
         dir_up_q      <= dir_up_d;
`ifdef LEVEL_CLASSIFIER_DWELL_EN
         pend_q        <= pend_d;
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign class_out   = class_q;
   assign class_valid = class_valid_q;
   assign changed     = changed_q;
   assign dir_up      = dir_up_q;

endmodule

// File: doc/level_classifier.md
# level_classifier

Parametrised successor to the fixed 3-band range classifier. Maps a WIDTH-bit sample onto one of N_CLASS ordered bands using run-time programmable thresholds, downward hysteresis and a dwell (debounce) filter, so the class only moves after a stable run of samples. It sits between the sensor-sample path and the mood state logic and produces a registered class plus change events.

## Interface
- WIDTH, 7: sample and threshold width.
- N_CLASS, 3: number of bands. Legal range is 2..8.
- CLASS_W, $clog2(N_CLASS): class output width (derived).
- HYST, 2: downward hysteresis margin, in LSBs.
- DWELL, 4: consecutive agreeing samples required to change class. Minimum 1.
- THR_INIT, {7'd96, 7'd32}: packed reset thresholds T[N_CLASS-2:0], with T[0] in the LSBs.
- RESET_CLASS, 0: class after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sample  in  WIDTH  input value.
- sample_valid  in  1  sample qualifier.
- thr_we  in  1  threshold write strobe.
- thr_idx  in  3  threshold index. Writes with idx ≥ N_CLASS-1 are ignored.
- thr_data  in  WIDTH  new threshold value.
- class_out  out  CLASS_W  current class (registered).
- class_valid  out  1  one-cycle pulse per accepted sample.
- changed  out  1  one-cycle pulse when class_out changes.
- dir_up  out  1  direction of the last change: 1 = up. Valid when changed=1.

## Operation
- raw = number of i with sample ≥ T[i]. Count semantics, so non-monotonic thresholds are still well-defined.
- Candidate computation, with c = current class:
  - If raw ≥ c: cand = raw.
  - Otherwise: cand = min(c, number of i with sample ≥ sat0(T[i]-HYST)). Subtraction saturates at 0.
- Dwell filter state: pend (CLASS_W bits) and cnt (width $clog2(DWELL+1)). The filter only acts on cycles with sample_valid=1.
  - cand == c: cnt ← 0.
  - cand ≠ c and cand == pend: cnt ← cnt+1.
  - cand ≠ c and cand ≠ pend: pend ← cand and cnt ← 1.
  - When the resulting count reaches DWELL: c ← cand, cnt ← 0, changed pulses, and dir_up ← (cand > c).
- Jumps across several bands (e.g. 0→2) take one change event.
- Threshold write: T[thr_idx] ← thr_data and cnt ← 0. If a write and a sample occur in the same cycle, the sample is evaluated with the old thresholds and its dwell update is discarded.
- Reset values:
  - class_out = RESET_CLASS.
  - class_valid, changed, dir_up, cnt, pend = 0.
  - T = THR_INIT.
- Reset has priority over every other input. Reset in the middle of a dwell run discards the partial count.

## Timing
- Latency is 1 cycle: the sample on edge k updates class_out, class_valid, changed and dir_up after edge k+1.
- class_valid follows sample_valid with a 1-cycle delay, including cycles where the sample is discarded by a threshold write.
- There is no backpressure. One sample can be accepted every cycle.
- A threshold write is visible to samples presented from the next cycle onward.
- Idle cycles (sample_valid=0) hold all filter state. Dwell counts consecutive valid samples, not cycles.

## Configuration
- Macro: LEVEL_CLASSIFIER_DWELL_EN.
- Defined: the dwell filter operates as described above.
- Undefined: pend and cnt are not built, and DWELL is ignored. Any cand ≠ c updates the class on the next edge (equivalent to DWELL=1). Hysteresis and threshold writes are unchanged.

## Structure
- Package level_classifier_pkg holds:
  - a class_w(n) function;
  - localparam MAX_CLASS = 8;
  - the default threshold constants DEF_THR_LO = 32 and DEF_THR_HI = 96.
- Sub-module level_classifier_cand is purely combinational. It takes sample, the threshold vector, c and HYST, and returns cand.
- The top level holds the threshold registers, the dwell filter and the output registers.

## Test plan
All scenarios use defaults (WIDTH=7, N_CLASS=3, HYST=2, DWELL=4) unless stated.
1. Reset, then idle: class_out=0, class_valid=0, changed=0, T={96,32}.
2. Samples 40,40,40,10,40,40,40,40: no change through the 4th sample. After the 8th sample, class_out=1, changed=1 and dir_up=1 for exactly one cycle.
3. From class 1, samples 31,30 each ×4: class stays 1. Then 29 ×4: class becomes 0, changed=1, dir_up=0.
4. From class 0, 120 ×4: class_out jumps to 2 with a single changed pulse. Then 94 ×4 keeps class 2, and 93 ×4 moves it to 1.
5. In class 2, write thr_idx=1, thr_data=64 in the same cycle as sample 50: that sample is discarded. Then 62 ×4 keeps class 2, and 61 ×4 moves it to 1. A write with thr_idx=5 changes nothing.
6. Three samples of 40, then a one-cycle rst, then one sample of 40: class_out=0. Rebuild with LEVEL_CLASSIFIER_DWELL_EN undefined: a single sample of 40 moves the class to 1 after the next edge.
